game_ctrl: RTL

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_if.sv | 25 ++
 rtl/game_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl_if.sv
// Game controller bus: keyboard bytes, vsync and game events in;
// physics strobe, paddle direction, launch, state and lives out.
// master = stimulus/game-logic side, slave = the controller itself.
interface game_ctrl_if;
  logic [7:0] ps2_byte;
  logic       ps2_valid;
  logic       vs;
  logic       ball_lost;
  logic       bricks_clear;
  logic       update_en;
  logic [1:0] paddle_dir;
  logic       launch;
  logic [2:0] state;
  logic [2:0] lives;

  modport master (
    output ps2_byte, ps2_valid, vs, ball_lost, bricks_clear,
    input  update_en, paddle_dir, launch, state, lives
  );

  modport slave (
    input  ps2_byte, ps2_valid, vs, ball_lost, bricks_clear,
    output update_en, paddle_dir, launch, state, lives
  );
endinterface

// File: rtl/game_ctrl.sv
// Breakout-style game sequencer: PS/2 scan decode, vsync-derived update
// tick, paddle direction and game state/lives tracking.
// Optional pause feature: define GAME_CTRL_PAUSE_EN.
//
// state | meaning
// IDLE  | waiting for space to start a new game
// SERVE | ball on paddle, space launches it
// PLAY  | ball in motion
// PAUSE | frozen, P resumes (GAME_CTRL_PAUSE_EN only)
// OVER  | no lives left, space returns to IDLE
// WIN   | all bricks cleared, space returns to IDLE
module game_ctrl #(
  parameter int FRAME_DIV  = 2,
  parameter int LIVES_INIT = 3
) (
  input  logic          clk_in,
  input  logic          reset,
  game_ctrl_if.slave    gc_if
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_t;

  localparam logic [3:0] FDIV_M1 = 4'(FRAME_DIV - 1);
  localparam logic [2:0] LIVES0  = 3'(LIVES_INIT);

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       frame_evt;
  logic [3:0] fcnt_q, fcnt_d;
  logic       upd_q, upd_d;
  logic       launch_q, launch_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       left_q, left_d, right_q, right_d;
  logic [1:0] dir_q, dir_d;
  logic       key_evt, space_press;
`ifdef GAME_CTRL_PAUSE_EN
  logic       p_press;
`endif

  // Sync flops reset low so a fresh high-then-low vs is needed for a frame.
  assign frame_evt = vs_s3_q & ~vs_s2_q;

  // Scan-code prefix tracking and held-key state.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    left_d  = left_q;
    right_d = right_q;
    key_evt = 1'b0;
    if (gc_if.ps2_valid) begin
      if (gc_if.ps2_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (gc_if.ps2_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        key_evt = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        if (gc_if.ps2_byte == 8'h6B) left_d  = ~brk_q;
        if (gc_if.ps2_byte == 8'h74) right_d = ~brk_q;
      end
    end
  end

  assign space_press = key_evt & ~brk_q & (gc_if.ps2_byte == 8'h29);
`ifdef GAME_CTRL_PAUSE_EN
  assign p_press     = key_evt & ~brk_q & (gc_if.ps2_byte == 8'h4D);
`endif

  // Game state sequencing; ball/brick events outrank key commands.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    launch_d = 1'b0;
    case (state_q)
      ST_IDLE: if (space_press) begin
        state_d = ST_SERVE;
        lives_d = LIVES0;
      end
      ST_SERVE: if (space_press) begin
        state_d  = ST_PLAY;
        launch_d = 1'b1;
      end
      ST_PLAY: begin
        if (gc_if.bricks_clear) begin
          state_d = ST_WIN;
        end else if (gc_if.ball_lost) begin
          if (lives_q > 3'd1) begin
            state_d = ST_SERVE;
            lives_d = lives_q - 3'd1;
          end else begin
            state_d = ST_OVER;
            lives_d = 3'd0;
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (p_press) begin
          state_d = ST_PAUSE;
        end
`endif
      end
`ifdef GAME_CTRL_PAUSE_EN
      ST_PAUSE: if (p_press) state_d = ST_PLAY;
`endif
      ST_OVER, ST_WIN: if (space_press) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame divider runs only while the ball is in service or play.
  always_comb begin
    fcnt_d = fcnt_q;
    upd_d  = 1'b0;
    if ((state_q == ST_SERVE || state_q == ST_PLAY) && frame_evt) begin
      if (fcnt_q == FDIV_M1) begin
        fcnt_d = 4'd0;
        upd_d  = 1'b1;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end
  end

  // Paddle direction from next-cycle held keys, gated by next state.
  always_comb begin
    dir_d = 2'b00;
    if (state_d == ST_SERVE || state_d == ST_PLAY) begin
      case ({right_d, left_d})
        2'b01:   dir_d = 2'b01;
        2'b10:   dir_d = 2'b10;
        default: dir_d = 2'b00;
      endcase
    end
  end

  // All state and output registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lives_q  <= LIVES0;
      vs_s1_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
      vs_s3_q  <= 1'b0;
      fcnt_q   <= 4'd0;
      upd_q    <= 1'b0;
      launch_q <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      dir_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      vs_s1_q  <= gc_if.vs;
      vs_s2_q  <= vs_s1_q;
      vs_s3_q  <= vs_s2_q;
      fcnt_q   <= fcnt_d;
      upd_q    <= upd_d;
      launch_q <= launch_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      left_q   <= left_d;
      right_q  <= right_d;
      dir_q    <= dir_d;
    end
  end

  assign gc_if.state      = state_q;
  assign gc_if.lives      = lives_q;
  assign gc_if.update_en  = upd_q;
  assign gc_if.launch     = launch_q;
  assign gc_if.paddle_dir = dir_q;

endmodule
